// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: MEM/WB pipeline register with load formatting, write-back select, forwarding hits and retire counter.
module mem_wb_writeback #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_reg_write,
  input  logic [4:0]       in_dst,
  input  logic [1:0]       in_wb_sel,
  input  logic [2:0]       in_load_type,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_mem_rdata,
  input  logic [XLEN-1:0]  in_pc_plus8,
  input  logic [4:0]       fwd_addr_a,
  input  logic [4:0]       fwd_addr_b,
  output logic             Write_Reg,
  output logic [4:0]       W_Addr,
  output logic [XLEN-1:0]  W_Data,
  output logic             fwd_hit_a,
  output logic             fwd_hit_b,
  output logic [CNT_W-1:0] retired
);
  logic            valid, reg_write;
  logic [4:0]      dst;
  logic [1:0]      wb_sel;
  logic [2:0]      load_type;
  logic [XLEN-1:0] alu_result, mem_rdata, pc_plus8;
  logic [7:0]      byte_val;
  logic [15:0]     half_val;
  logic [XLEN-1:0] load_val;
  // The occupant leaves on any flush, even one that overrides a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= 1'b0;
      reg_write  <= 1'b0;
      dst        <= '0;
      wb_sel     <= '0;
      load_type  <= '0;
      alu_result <= '0;
      mem_rdata  <= '0;
      pc_plus8   <= '0;
      retired    <= '0;
    end else begin
      if (valid && (!stall || flush)) retired <= retired + 1'b1;
      if (flush) begin
        valid     <= 1'b0;
        reg_write <= 1'b0;
      end else if (!stall) begin
        valid      <= in_valid;
        reg_write  <= in_reg_write;
        dst        <= in_dst;
        wb_sel     <= in_wb_sel;
        load_type  <= in_load_type;
        alu_result <= in_alu_result;
        mem_rdata  <= in_mem_rdata;
        pc_plus8   <= in_pc_plus8;
      end
    end
  end
  always_comb begin
    byte_val  = 8'(mem_rdata >> {alu_result[1:0], 3'b000});
    half_val  = alu_result[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_val  = load_type == 3'd1 ? {{24{byte_val[7]}}, byte_val} :
                load_type == 3'd2 ? {24'b0, byte_val} :
                load_type == 3'd3 ? {{16{half_val[15]}}, half_val} :
                load_type == 3'd4 ? {16'b0, half_val} : mem_rdata;
    Write_Reg = valid & reg_write & (dst != 5'd0);
    W_Addr    = Write_Reg ? dst : 5'd0;
    W_Data    = !Write_Reg ? '0 :
                wb_sel == 2'd2 ? pc_plus8 :
                wb_sel == 2'd1 ? load_val : alu_result;
    fwd_hit_a = Write_Reg & (fwd_addr_a == W_Addr);
    fwd_hit_b = Write_Reg & (fwd_addr_b == W_Addr);
  end
endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb_mem_wb_writeback: directed vectors with hand-computed expectations for mem_wb_writeback.
module tb_mem_wb_writeback;
  logic        clk = 0, rst, stall, flush, in_valid, in_reg_write;
  logic [4:0]  in_dst, fwd_addr_a, fwd_addr_b, W_Addr;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_load_type;
  logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus8, W_Data, retired;
  logic        Write_Reg, fwd_hit_a, fwd_hit_b;
  int tests = 0, fails = 0;

  mem_wb_writeback dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_dst(in_dst),
    .in_wb_sel(in_wb_sel), .in_load_type(in_load_type),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata), .in_pc_plus8(in_pc_plus8),
    .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b),
    .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] d, input logic [1:0] sel,
                       input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] mem);
    in_valid = v; in_reg_write = rw; in_dst = d; in_wb_sel = sel;
    in_load_type = lt; in_alu_result = alu; in_mem_rdata = mem;
  endtask

  task automatic chk_wb(input string tag, input logic wr, input logic [4:0] a,
                        input logic [31:0] d, input logic [31:0] r);
    chk({tag, ".wr"}, 32'(Write_Reg), 32'(wr));
    chk({tag, ".addr"}, 32'(W_Addr), 32'(a));
    chk({tag, ".data"}, W_Data, d);
    chk({tag, ".ret"}, retired, r);
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; in_pc_plus8 = 32'h0;
    fwd_addr_a = 0; fwd_addr_b = 0;
    drive(1, 1, 5'd7, 0, 0, 32'h1111_1111, 32'h0);
    step(); step();
    rst = 0;
    chk_wb("reset", 0, 0, 0, 0);
    chk("reset.hit_a", 32'(fwd_hit_a), 0);
    chk("reset.hit_b", 32'(fwd_hit_b), 0);

    drive(1, 1, 5'd8, 0, 0, 32'h0000_002A, 32'h0);
    fwd_addr_a = 8; fwd_addr_b = 7;
    step();
    chk_wb("alu", 1, 8, 32'h2A, 0);
    chk("alu.hit_a", 32'(fwd_hit_a), 1);
    chk("alu.hit_b", 32'(fwd_hit_b), 0);

    drive(1, 1, 5'd9, 1, 1, 32'h0000_1001, 32'h1234_80FF); step();
    chk_wb("lb", 1, 9, 32'hFFFF_FF80, 1);
    drive(1, 1, 5'd9, 1, 2, 32'h0000_1001, 32'h1234_80FF); step();
    chk_wb("lbu", 1, 9, 32'h0000_0080, 2);
    drive(1, 1, 5'd9, 1, 3, 32'h0000_1002, 32'h8001_1234); step();
    chk_wb("lh", 1, 9, 32'hFFFF_8001, 3);
    drive(1, 1, 5'd9, 1, 4, 32'h0000_1002, 32'h8001_1234); step();
    chk_wb("lhu", 1, 9, 32'h0000_8001, 4);
    drive(1, 1, 5'd9, 1, 0, 32'h0000_1002, 32'h8001_1234); step();
    chk_wb("lw", 1, 9, 32'h8001_1234, 5);
    drive(1, 1, 5'd9, 1, 7, 32'h0000_1003, 32'h8001_1234); step();
    chk_wb("lw7", 1, 9, 32'h8001_1234, 6);
    drive(1, 1, 5'd9, 1, 1, 32'h0000_1003, 32'h1234_80FF); step();
    chk_wb("lb3", 1, 9, 32'h0000_0012, 7);
    drive(1, 1, 5'd9, 1, 2, 32'h0000_1000, 32'h1234_80FF); step();
    chk_wb("lbu0", 1, 9, 32'h0000_00FF, 8);

    drive(1, 1, 5'd0, 0, 0, 32'hDEAD_BEEF, 32'h0);
    fwd_addr_a = 0; fwd_addr_b = 0;
    step();
    chk_wb("r0", 0, 0, 0, 9);
    chk("r0.hit_a", 32'(fwd_hit_a), 0);

    drive(1, 1, 5'd31, 2, 0, 32'h0000_0044, 32'h0);
    in_pc_plus8 = 32'h0040_0010; fwd_addr_a = 31; fwd_addr_b = 31;
    step();
    chk_wb("link", 1, 31, 32'h0040_0010, 10);
    chk("link.hit_a", 32'(fwd_hit_a), 1);
    chk("link.hit_b", 32'(fwd_hit_b), 1);

    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5'(3 + i), 0, 0, 32'h5555_0000 + 32'(i), 32'h0);
      step();
      chk_wb("stall", 1, 31, 32'h0040_0010, 10);
    end
    flush = 1; step();
    chk_wb("flush", 0, 0, 0, 11);
    chk("flush.hit_a", 32'(fwd_hit_a), 0);
    flush = 0; stall = 0;
    drive(0, 1, 5'd6, 0, 0, 32'h0000_0099, 32'h0); step();
    chk_wb("bubble", 0, 0, 0, 11);

    drive(1, 1, 5'd5, 0, 0, 32'h0000_0077, 32'h0); step();
    chk_wb("pre_rst", 1, 5, 32'h77, 11);
    stall = 1; rst = 1; step();
    chk_wb("mid_rst", 0, 0, 0, 0);
    rst = 0; stall = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
